// File: rtl/inst_mem_pkg.sv
// rtl/inst_mem_pkg.sv - shared types, constants and fetch address checks for the loadable instruction memory
package inst_mem_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        LOAD  = 2'd2
    } state_e;

    localparam logic [31:0] NOP_JUMP0 = 32'h0800_0000;

    typedef struct packed {
        logic in_range;
        logic aligned;
    } fetch_chk_t;

    // in_range: no address bits set above the word index for this depth.
    function automatic fetch_chk_t fetch_check(input logic [31:0] addr, input int unsigned depth_log2);
        fetch_chk_t chk;
        chk.aligned  = (addr[1:0] == 2'b00);
        chk.in_range = ((addr >> (depth_log2 + 32'd2)) == 32'd0);
        return chk;
    endfunction

endpackage

// File: rtl/inst_mem_array.sv
// rtl/inst_mem_array.sv - word storage with one synchronous write port and one registered read port
module inst_mem_array #(
    parameter int unsigned DEPTH_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [31:0]           wdata_i,
    input  logic                  re_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem_q [2**DEPTH_LOG2];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_rom_loadable.sv
// rtl/inst_rom_loadable.sv - instruction memory with post-reset clear sweep and streaming program load
module inst_rom_loadable
    import inst_mem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2   = 5,
    parameter logic [31:0] DEFAULT_WORD = NOP_JUMP0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        rd_en,
    output logic [31:0] data,
    output logic        data_valid,
    output logic        fault,
    input  logic        ld_start,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        ld_done,
    output logic        busy
);

    localparam logic [DEPTH_LOG2-1:0] PTR_LAST = '1;

    state_e                state_q, state_d;
    logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
    logic                  valid_q, valid_d;
    logic                  fault_q, fault_d;
    logic                  sel_q, sel_d;
    logic                  done_q, done_d;

    logic                  mem_we;
    logic [31:0]           mem_wdata;
    logic                  mem_re;
    logic [31:0]           mem_rdata;
    logic                  fetch;
    fetch_chk_t            chk;

    assign chk = fetch_check(addr, DEPTH_LOG2);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        mem_we    = 1'b0;
        mem_wdata = DEFAULT_WORD;
        fetch     = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            CLEAR: begin
                mem_we = 1'b1;
                ptr_d  = ptr_q + 1'b1;
                if (ptr_q == PTR_LAST) begin
                    state_d = RUN;
                    ptr_d   = '0;
                end
            end
            RUN: begin
                fetch = rd_en;
                if (ld_start) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                end
            end
            LOAD: begin
                if (ld_valid) begin
                    mem_we    = 1'b1;
                    mem_wdata = ld_data;
                    ptr_d     = ptr_q + 1'b1;
                    // The terminal slot ends the load even without ld_last so ptr never wraps.
                    if (ld_last || (ptr_q == PTR_LAST)) begin
                        state_d = RUN;
                        ptr_d   = '0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    assign mem_re = fetch && chk.aligned && chk.in_range;

    always_comb begin
        valid_d = fetch;
        fault_d = fault_q;
        sel_d   = sel_q;
        if (fetch) begin
            fault_d = !chk.aligned;
            sel_d   = chk.aligned && chk.in_range;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            sel_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
        end
    end

    inst_mem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk    (clk),
        .we_i   (mem_we),
        .waddr_i(ptr_q),
        .wdata_i(mem_wdata),
        .re_i   (mem_re),
        .raddr_i(addr[DEPTH_LOG2+1:2]),
        .rdata_o(mem_rdata)
    );

    // sel_q picks the registered array word; otherwise the default word, which also covers reset.
    assign data       = sel_q ? mem_rdata : DEFAULT_WORD;
    assign data_valid = valid_q;
    assign fault      = fault_q;
    assign ld_ready   = (state_q == LOAD);
    assign ld_done    = done_q;
    assign busy       = (state_q != RUN);

endmodule

// File: tb/tb_inst_rom_loadable.sv
// tb/tb_inst_rom_loadable.sv - directed scoreboard bench for inst_rom_loadable
module tb_inst_rom_loadable;

    localparam logic [31:0] DEF = 32'h0800_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        rd_en;
    logic [31:0] data;
    logic        data_valid;
    logic        fault;
    logic        ld_start;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        ld_done;
    logic        busy;

    typedef struct packed {
        logic [31:0] data;
        logic        fault;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_mem [32];
    int          n_assert = 0;
    int          n_fail   = 0;

    inst_rom_loadable #(
        .DEPTH_LOG2  (5),
        .DEFAULT_WORD(32'h0800_0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .rd_en     (rd_en),
        .data      (data),
        .data_valid(data_valid),
        .fault     (fault),
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .ld_ready  (ld_ready),
        .ld_done   (ld_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_data"},       data,       DEF);
        chk({tag, "_data_valid"}, data_valid, 32'd0);
        chk({tag, "_fault"},      fault,      32'd0);
        chk({tag, "_ld_ready"},   ld_ready,   32'd0);
        chk({tag, "_ld_done"},    ld_done,    32'd0);
        chk({tag, "_busy"},       busy,       32'd1);
    endtask

    function automatic exp_t model_fetch(input logic [31:0] a);
        exp_t e;
        if (a[1:0] != 2'b00) begin
            e.data  = DEF;
            e.fault = 1'b1;
        end else if (a[31:7] != 25'd0) begin
            e.data  = DEF;
            e.fault = 1'b0;
        end else begin
            e.data  = model_mem[a[6:2]];
            e.fault = 1'b0;
        end
        return e;
    endfunction

    task automatic check_response(input string tag);
        exp_t e;
        chk({tag, "_valid"}, data_valid, 32'd1);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_data"},  data,  e.data);
            chk({tag, "_fault"}, fault, e.fault);
        end
    endtask

    task automatic fetch(input string tag, input logic [31:0] a);
        addr  = a;
        rd_en = 1'b1;
        sb_q.push_back(model_fetch(a));
        cycle();
        rd_en = 1'b0;
        check_response(tag);
    endtask

    task automatic wait_clear(input string tag);
        int cnt = 0;
        while (busy && cnt < 100) begin
            cycle();
            cnt++;
        end
        chk({tag, "_clear_cycles"}, cnt, 32'd32);
        for (int i = 0; i < 32; i++) model_mem[i] = DEF;
    endtask

    task automatic start_load(input string tag);
        ld_start = 1'b1;
        cycle();
        ld_start = 1'b0;
        chk({tag, "_ld_ready_up"}, ld_ready, 32'd1);
    endtask

    task automatic beat(input logic [31:0] w, input logic last, input int idx);
        ld_valid = 1'b1;
        ld_data  = w;
        ld_last  = last;
        model_mem[idx] = w;
        cycle();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    initial begin
        logic [31:0] held;
        reset    = 1'b1;
        addr     = 32'd0;
        rd_en    = 1'b0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_data  = 32'd0;
        ld_last  = 1'b0;
        cycle();
        cycle();
        check_reset_values("reset");

        reset = 1'b0;
        wait_clear("init");
        fetch("fetch_7c_first_run", 32'h0000_007C);

        // Three-beat load with ld_last, then read back including write-before-read.
        start_load("ld3");
        beat(32'h3c11_4000, 1'b0, 0);
        chk("ld3_beat1_no_done", ld_done, 32'd0);
        beat(32'h2631_0004, 1'b0, 1);
        beat(32'h2410_00aa, 1'b1, 2);
        chk("ld3_done",     ld_done,  32'd1);
        chk("ld3_ready_lo", ld_ready, 32'd0);
        chk("ld3_busy_lo",  busy,     32'd0);
        fetch("ld3_fetch_8_wbr", 32'h0000_0008);
        chk("ld3_done_single_pulse", ld_done, 32'd0);
        fetch("ld3_fetch_0", 32'h0000_0000);
        fetch("ld3_fetch_4", 32'h0000_0004);
        fetch("ld3_fetch_c", 32'h0000_000C);

        // Full-depth load without ld_last must terminate on the 32nd beat.
        start_load("ld32");
        for (int i = 0; i < 32; i++) begin
            beat($urandom, 1'b0, i);
            if (i < 31) chk("ld32_ready_mid", ld_ready, 32'd1);
        end
        chk("ld32_done",     ld_done,  32'd1);
        chk("ld32_ready_lo", ld_ready, 32'd0);
        ld_valid = 1'b1;
        ld_data  = 32'hDEAD_BEEF;
        chk("ld32_beat33_not_ready", ld_ready, 32'd0);
        cycle();
        ld_valid = 1'b0;
        chk("ld32_beat33_busy", busy, 32'd0);
        fetch("ld32_fetch_0",  32'h0000_0000);
        fetch("ld32_fetch_40", 32'h0000_0040);
        fetch("ld32_fetch_7c", 32'h0000_007C);

        // Misaligned and out-of-range fetches, then hold when idle.
        fetch("misaligned_6", 32'h0000_0006);
        fetch("oor_80",       32'h0000_0080);
        fetch("oor_high",     32'h8000_0010);
        fetch("fetch_10",     32'h0000_0010);
        held = data;
        addr = 32'h0000_0006;
        cycle();
        chk("idle_valid_lo", data_valid, 32'd0);
        chk("idle_data_hold", data, held);

        // ld_start with a concurrent fetch, then a fetch attempt during LOAD.
        addr     = 32'h0000_0004;
        rd_en    = 1'b1;
        ld_start = 1'b1;
        sb_q.push_back(model_fetch(32'h0000_0004));
        cycle();
        rd_en    = 1'b0;
        ld_start = 1'b0;
        check_response("start_and_fetch");
        chk("start_and_fetch_ready", ld_ready, 32'd1);
        held  = data;
        addr  = 32'h0000_0008;
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        chk("load_fetch_valid_lo", data_valid, 32'd0);
        chk("load_fetch_data_hold", data, held);
        chk("load_busy", busy, 32'd1);
        beat(32'h1234_5678, 1'b1, 0);
        chk("ld1_done", ld_done, 32'd1);
        fetch("ld1_fetch_0", 32'h0000_0000);
        fetch("ld1_fetch_4", 32'h0000_0004);

        // Reset in the middle of a load discards the program.
        start_load("ldrst");
        beat(32'hAAAA_0001, 1'b0, 0);
        beat(32'hAAAA_0002, 1'b0, 1);
        reset = 1'b1;
        #1;
        check_reset_values("midload_reset");
        @(negedge clk);
        cycle();
        reset = 1'b0;
        wait_clear("post_reset");
        fetch("post_reset_fetch_0", 32'h0000_0000);
        fetch("post_reset_fetch_4", 32'h0000_0004);
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
